// File: rtl/vga_timing_recovery_pkg.sv
// rtl/vga_timing_recovery_pkg.sv - shared recovery FSM states and default 640x480 timing constants
package vga_timing_recovery_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rec_state_t;

  localparam int VGA_WIDTH          = 800;
  localparam int VGA_HEIGHT         = 525;
  localparam int VGA_WIDTH_VISIBLE  = 640;
  localparam int VGA_HEIGHT_VISIBLE = 480;
  localparam int VGA_H_SYNC_START   = 656;
  localparam int VGA_V_SYNC_START   = 490;
  localparam int VGA_H_SYNC_WIDTH   = 96;
  localparam int VGA_V_SYNC_WIDTH   = 2;

endpackage

// File: rtl/vga_timing_recovery_sync_edge_detect.sv
// rtl/vga_timing_recovery_sync_edge_detect.sv - sync input register, polarity normalise, assertion edge
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sync,
  output logic o_edge
);

  logic r_sync;
  logic r_prev;

  // register the sync once (normalised so 1 = asserted) and keep its previous value
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= i_sync ^ ACTIVE_LOW;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/vga_timing_recovery.sv
// rtl/vga_timing_recovery.sv - recovers x/y position and lock from incoming syncs (optional VGA_TIMING_RECOVERY_MEASURE_EN)
module vga_timing_recovery
  import vga_timing_recovery_pkg::*;
#(
  parameter int WIDTH           = VGA_WIDTH,
  parameter int HEIGHT          = VGA_HEIGHT,
  parameter int WIDTH_VISIBLE   = VGA_WIDTH_VISIBLE,
  parameter int HEIGHT_VISIBLE  = VGA_HEIGHT_VISIBLE,
  parameter int H_SYNC_START    = VGA_H_SYNC_START,
  parameter int V_SYNC_START    = VGA_V_SYNC_START,
  parameter int LOCK_LINES      = 4,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int BIT_DEPTH       = 11
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  output logic [BIT_DEPTH-1:0] o_x,
  output logic [BIT_DEPTH-1:0] o_y,
  output logic                 o_visible,
  output logic                 o_locked,
`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
  output logic [BIT_DEPTH-1:0] o_line_len,
  output logic [BIT_DEPTH-1:0] o_frame_lines,
`endif
  output logic                 o_frame_start
);

  localparam int LCW = $clog2(LOCK_LINES + 1);
  localparam logic [LCW-1:0]       LOCK_CNT = LCW'(LOCK_LINES);
  localparam logic [LCW-1:0]       CNT_ONE  = LCW'(1);
  localparam logic [BIT_DEPTH-1:0] ONE      = BIT_DEPTH'(1);
  localparam logic [BIT_DEPTH-1:0] X_LAST   = BIT_DEPTH'(WIDTH - 1);
  localparam logic [BIT_DEPTH-1:0] Y_LAST   = BIT_DEPTH'(HEIGHT - 1);
  localparam logic [BIT_DEPTH-1:0] X_VIS    = BIT_DEPTH'(WIDTH_VISIBLE);
  localparam logic [BIT_DEPTH-1:0] Y_VIS    = BIT_DEPTH'(HEIGHT_VISIBLE);
  localparam logic [BIT_DEPTH-1:0] HS_X     = BIT_DEPTH'(H_SYNC_START);
  localparam logic [BIT_DEPTH-1:0] VS_Y     = BIT_DEPTH'(V_SYNC_START);
  localparam bit                   POL_LOW  = (SYNC_ACTIVE_LOW != 0);

  logic                 h_edge;
  logic                 v_edge;
  logic [BIT_DEPTH-1:0] r_x;
  logic [BIT_DEPTH-1:0] r_y;
  logic [BIT_DEPTH-1:0] nat_x;
  logic [BIT_DEPTH-1:0] nat_y;
  logic                 h_match;
  logic                 v_match;
  rec_state_t           r_state;
  logic [LCW-1:0]       r_count;
  logic                 r_v_seen;
  logic                 r_locked;

  sync_edge_detect #(.ACTIVE_LOW(POL_LOW)) u_hsync_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sync    (i_hsync),
    .o_edge    (h_edge)
  );

  sync_edge_detect #(.ACTIVE_LOW(POL_LOW)) u_vsync_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sync    (i_vsync),
    .o_edge    (v_edge)
  );

  // natural (free-running) next position, same stepping as the timing generator
  always_comb begin
    nat_x = r_x + ONE;
    nat_y = r_y;
    if (r_x == X_LAST) begin
      nat_x = '0;
      nat_y = (r_y == Y_LAST) ? '0 : r_y + ONE;
    end
  end

  assign h_match = h_edge && (nat_x == HS_X);
  assign v_match = v_edge && (nat_y == VS_Y);

  // position counters: free-run, but snap to the sync start on each sync edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= h_edge ? HS_X : nat_x;
      r_y <= v_edge ? VS_Y : nat_y;
    end
  end

  // lock FSM: find an hsync, count consistent lines plus one consistent vsync, then watch for breaks
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= SEARCH;
      r_count  <= '0;
      r_v_seen <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        SEARCH: begin
          r_locked <= 1'b0;
          if (h_edge) begin
            r_state  <= TRACK;
            r_count  <= '0;
            r_v_seen <= 1'b0;
          end
        end
        TRACK: begin
          if (h_edge) begin
            if (h_match) r_count <= (r_count == LOCK_CNT) ? r_count : r_count + CNT_ONE;
            else         r_count <= '0;
          end
          if (v_match) r_v_seen <= 1'b1;
          if (r_count == LOCK_CNT && r_v_seen) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if ((h_edge && !h_match) || (v_edge && !v_match) || (!h_edge && nat_x == HS_X)) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_locked      = r_locked;
  assign o_visible     = r_locked && (r_x < X_VIS) && (r_y < Y_VIS);
  assign o_frame_start = r_locked && (r_x == '0) && (r_y == '0);

`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
  localparam logic [BIT_DEPTH-1:0] CNT_MAX = '1;

  logic [BIT_DEPTH-1:0] r_line_cnt;
  logic [BIT_DEPTH-1:0] r_frame_cnt;
  logic [BIT_DEPTH-1:0] r_line_len;
  logic [BIT_DEPTH-1:0] r_frame_lines;

  // clocks between hsync edges and hsync edges between vsync edges, saturating
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_line_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
    end else begin
      if (h_edge) begin
        r_line_len <= r_line_cnt;
        r_line_cnt <= ONE;
      end else if (r_line_cnt != CNT_MAX) begin
        r_line_cnt <= r_line_cnt + ONE;
      end
      if (v_edge) begin
        r_frame_lines <= r_frame_cnt;
        r_frame_cnt   <= h_edge ? ONE : '0;
      end else if (h_edge && r_frame_cnt != CNT_MAX) begin
        r_frame_cnt <= r_frame_cnt + ONE;
      end
    end
  end

  assign o_line_len    = r_line_len;
  assign o_frame_lines = r_frame_lines;
`endif

endmodule

// File: tb/tb_vga_timing_recovery.sv
// tb/tb_vga_timing_recovery.sv - directed bench for vga_timing_recovery on a reduced 40x20 raster
module tb_vga_timing_recovery;

  localparam int W     = 40;
  localparam int H     = 20;
  localparam int WV    = 32;
  localparam int HV    = 15;
  localparam int HS    = 34;
  localparam int VS    = 17;
  localparam int HW    = 4;
  localparam int VW    = 2;
  localparam int FRAME = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        hs_n, vs_n, hs_p, vs_p;
  logic [10:0] x_n, y_n, x_p, y_p;
  logic        vis_n, lock_n, fs_n, vis_p, lock_p, fs_p;
`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
  logic [10:0] ll_n, fl_n, ll_p, fl_p;
`endif

  vga_timing_recovery #(
    .WIDTH(W), .HEIGHT(H), .WIDTH_VISIBLE(WV), .HEIGHT_VISIBLE(HV),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_LINES(4),
    .SYNC_ACTIVE_LOW(1), .BIT_DEPTH(11)
  ) dut_n (
    .i_clk(clk), .i_reset_n(reset_n), .i_hsync(hs_n), .i_vsync(vs_n),
    .o_x(x_n), .o_y(y_n), .o_visible(vis_n), .o_locked(lock_n),
`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
    .o_line_len(ll_n), .o_frame_lines(fl_n),
`endif
    .o_frame_start(fs_n)
  );

  vga_timing_recovery #(
    .WIDTH(W), .HEIGHT(H), .WIDTH_VISIBLE(WV), .HEIGHT_VISIBLE(HV),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_LINES(4),
    .SYNC_ACTIVE_LOW(0), .BIT_DEPTH(11)
  ) dut_p (
    .i_clk(clk), .i_reset_n(reset_n), .i_hsync(hs_p), .i_vsync(vs_p),
    .o_x(x_p), .o_y(y_p), .o_visible(vis_p), .o_locked(lock_p),
`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
    .o_line_len(ll_p), .o_frame_lines(fl_p),
`endif
    .o_frame_start(fs_p)
  );

  int total = 0;
  int bad   = 0;
  int gx, gy, gx1, gy1, gx2, gy2;
  bit drop_h, early_h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bit hs, vs;
    hs = early_h ? (gx >= HS - 3 && gx < HS - 3 + HW) : (!drop_h && gx >= HS && gx < HS + HW);
    vs = (gy >= VS && gy < VS + VW);
    hs_n = !hs; hs_p = hs;
    vs_n = !vs; vs_p = vs;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    gx2 = gx1; gy2 = gy1; gx1 = gx; gy1 = gy;
    if (gx == W - 1) begin
      gx = 0;
      gy = (gy == H - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
    drive();
  endtask

  task automatic wait_gen(input int x, input int y, input string tag);
    int n = 0;
    while (!(gx == x && gy == y) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check(tag, (gx == x && gy == y), 1);
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (!lock_n && n < 3 * FRAME) begin
      tick();
      n++;
    end
    check(tag, lock_n, 1);
    check({tag, "_p"}, lock_p, 1);
    check({tag, "_pos"}, gy * W + gx, VS * W + 3);
  endtask

  initial begin
    int err_n, err_p, nfs_n, nfs_p, nvis_n, nvis_p;
    reset_n = 1'b0;
    drop_h = 0; early_h = 0;
    gx = 0; gy = 0; gx1 = 0; gy1 = 0; gx2 = 0; gy2 = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x_n, 0);
    check("rst_y", y_n, 0);
    check("rst_lock", lock_n, 0);
    check("rst_vis", vis_n, 0);
    check("rst_fs", fs_n, 0);
    reset_n = 1'b1;

    wait_lock("lock_first");

    err_n = 0; err_p = 0; nfs_n = 0; nfs_p = 0; nvis_n = 0; nvis_p = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (int'(x_n) != gx2 || int'(y_n) != gy2 || !lock_n) err_n++;
      if (int'(x_p) != gx2 || int'(y_p) != gy2 || !lock_p) err_p++;
      if (fs_n) begin
        nfs_n++;
        if (x_n != 0 || y_n != 0) err_n++;
      end
      if (fs_p) nfs_p++;
      if (vis_n) nvis_n++;
      if (vis_p) nvis_p++;
    end
    check("track_err_n", err_n, 0);
    check("track_err_p", err_p, 0);
    check("frame_start_n", nfs_n, 1);
    check("frame_start_p", nfs_p, 1);
    check("visible_n", nvis_n, WV * HV);
    check("visible_p", nvis_p, WV * HV);
`ifdef VGA_TIMING_RECOVERY_MEASURE_EN
    check("line_len_n", ll_n, W);
    check("frame_lines_n", fl_n, H);
    check("line_len_p", ll_p, W);
    check("frame_lines_p", fl_p, H);
`endif

    wait_gen(0, 5, "miss_reach");
    drop_h = 1;
    while (gx != HS + 1) tick();
    check("miss_pre_lock", lock_n, 1);
    tick();
    check("miss_lock", lock_n, 0);
    check("miss_x", x_n, HS);
    check("miss_lock_p", lock_p, 0);
    while (gx != HS + HW) tick();
    drop_h = 0;
    wait_lock("relock_miss");
    tick();
    check("relock_track_x", x_n, gx2);

    wait_gen(0, 8, "early_reach");
    early_h = 1;
    while (gx != HS - 2) tick();
    check("early_pre_lock", lock_n, 1);
    tick();
    check("early_x", x_n, HS);
    check("early_lock", lock_n, 0);
    check("early_lock_p", lock_p, 0);
    while (gx != HS + HW) tick();
    early_h = 0;
    wait_lock("relock_early");

    wait_gen(10, 5, "rst_mid_reach");
    check("rst_mid_pre_vis", vis_n, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_x", x_n, 0);
    check("rst_mid_y", y_n, 0);
    check("rst_mid_lock", lock_n, 0);
    check("rst_mid_vis", vis_n, 0);
    check("rst_mid_xp", x_p, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_mid_nolock", lock_n, 0);
    wait_lock("relock_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_recovery.md
VGA_TIMING_RECOVERY -- requirements
Module: vga_timing_recovery

Interface
REQ-001 SHALL have parameter WIDTH, 800, total clocks per line.
REQ-002 SHALL have parameter HEIGHT, 525, total lines per frame.
REQ-003 SHALL have parameter WIDTH_VISIBLE, 640, visible clocks per line.
REQ-004 SHALL have parameter HEIGHT_VISIBLE, 480, visible lines per frame.
REQ-005 SHALL have parameter H_SYNC_START, 656, x value at the first hsync-asserted pixel.
REQ-006 SHALL have parameter V_SYNC_START, 490, y value at the first vsync-asserted line.
REQ-007 SHALL have parameter LOCK_LINES, 4, consecutive matching hsync edges required for lock.
REQ-008 SHALL have parameter SYNC_ACTIVE_LOW, 1, sync polarity (1 = asserted low).
REQ-009 SHALL have parameter BIT_DEPTH, 11, counter width.
REQ-010 SHALL have port i_clk  input  1  pixel clock; reset i_reset_n, asynchronous, active-low; clock i_clk.
REQ-011 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-012 SHALL have port i_hsync  input  1  horizontal sync, synchronous to i_clk.
REQ-013 SHALL have port i_vsync  input  1  vertical sync, synchronous to i_clk.
REQ-014 SHALL have ports o_x, o_y  output  BIT_DEPTH  recovered pixel position.
REQ-015 SHALL have port o_visible  output  1  o_locked and o_x<WIDTH_VISIBLE and o_y<HEIGHT_VISIBLE.
REQ-016 SHALL have port o_locked  output  1  timing locked to input.
REQ-017 SHALL have port o_frame_start  output  1  one-cycle pulse when locked counters wrap to (0,0).

Function
REQ-018 SHALL register each sync input once, normalise polarity, and detect assertion edge as registered-asserted and previous-registered-deasserted.
REQ-019 SHALL free-run r_x 0..WIDTH-1 and r_y 0..HEIGHT-1 (y steps on x wrap, wraps at HEIGHT-1), identical stepping to the team's VGA timing generator.
REQ-020 SHALL on hsync edge load r_x with H_SYNC_START (r_y steps normally); input sync first asserted in cycle T gives o_x==H_SYNC_START in cycle T+2.
REQ-021 SHALL on vsync edge load r_y with V_SYNC_START; simultaneous h and v edges apply both loads.
REQ-022 SHALL define h-match as hsync edge where natural next r_x equals H_SYNC_START; v-match likewise for r_y and V_SYNC_START.
REQ-023 SHALL implement FSM SEARCH/TRACK/LOCKED; reset state SEARCH.
REQ-024 SEARCH: first hsync edge -> TRACK, match count 0, v_seen 0.
REQ-025 TRACK: h-match increments count (saturating at LOCK_LINES); h-mismatch clears count; v-match sets v_seen; count==LOCK_LINES and v_seen -> LOCKED.
REQ-026 LOCKED: h-mismatch, v-mismatch, or natural next r_x==H_SYNC_START without hsync edge (missed pulse) -> SEARCH; o_locked low the following cycle.
REQ-027 o_locked SHALL be high exactly while state is LOCKED; o_x/o_y SHALL be r_x/r_y in all states.
REQ-028 o_frame_start SHALL pulse only in LOCKED, in the cycle o_x==0 and o_y==0.

Reset
REQ-029 SHALL reset r_x, r_y, counters, sync registers (deasserted) to 0, state SEARCH; o_locked, o_visible, o_frame_start 0; o_x, o_y 0.
REQ-030 Reset mid-lock SHALL take effect immediately; relock requires a fresh full TRACK sequence.

Configuration
REQ-031 With VGA_TIMING_RECOVERY_MEASURE_EN defined SHALL add outputs o_line_len (BIT_DEPTH, clocks between last two hsync edges) and o_frame_lines (BIT_DEPTH, lines between last two vsync edges), both 0 at reset, updated on each edge.
REQ-032 Without the macro those ports and measurement counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold FSM state typedef (SEARCH, TRACK, LOCKED) and default 640x480 timing constants shared with the generator.
REQ-034 Sub-module sync_edge_detect (register, polarity, edge) SHALL be instantiated once per sync input.

Verification
REQ-035 Generator-timed syncs (hsync low x 656-751, vsync low y 490-491) -> o_locked high within first frame after 4 matching lines plus vsync; thereafter o_x/o_y equal generator x/y delayed 2 cycles.
REQ-036 Locked, one hsync pulse omitted -> o_locked low the cycle after natural x reaches 656; relock after 4 lines plus vsync.
REQ-037 Locked, one hsync 3 clocks early -> SEARCH, o_x loaded to 656, o_locked 0.
REQ-038 Locked full frame -> exactly one o_frame_start per 420000 clocks; o_visible count 307200 per frame.
REQ-039 Assert i_reset_n low mid-line while locked -> all outputs 0 immediately; SYNC_ACTIVE_LOW=0 with inverted syncs locks identically.
REQ-040 With VGA_TIMING_RECOVERY_MEASURE_EN: line length 800 -> o_line_len 800; frame 525 lines -> o_frame_lines 525.
